// File: rtl/ap_mult_err_eval.sv
// ap_mult_err_eval: exhaustive operand-sweep driver and error accumulator for
// approximate WxW compressor-tree multipliers that take a partial-product vector.
// Every (a,b) pair is issued once as pp_o. The returned product is compared with
// a*b, and the error count, sum and maximum of the absolute error are accumulated.
// Optional feature: define AP_ERR_LOG_EN to add a per-error log port
// (err_vld_o, err_a_o, err_b_o, err_diff_o).

module ap_mult_err_eval #(
    parameter int W     = 4,
    parameter int LAT   = 0,
    parameter int SUM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2*W-1:0]     res_i,
    output logic [W*W-1:0]     pp_o,
    output logic [W-1:0]       a_o,
    output logic [W-1:0]       b_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*W:0]       err_cnt_o,
    output logic [SUM_W-1:0]   err_sum_o,
    output logic [2*W-1:0]     err_max_o
`ifdef AP_ERR_LOG_EN
    ,
    output logic               err_vld_o,
    output logic [W-1:0]       err_a_o,
    output logic [W-1:0]       err_b_o,
    output logic [2*W:0]       err_diff_o
`endif
);

    localparam int PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Stage 0 of the index pipeline is the sweep index itself. Deeper stages
    // follow the pair until its product returns from the multiplier.
    logic            vld_pipe [0:LAT];
    logic [PW-1:0]   idx_pipe [0:LAT];
    logic [PW-1:0]   idx;
    logic [PW-1:0]   idx_inc;
    logic            last_issued;
    logic            issue_first;
    logic            issue_next;
    logic            pipe_busy;

    logic [W-1:0]    tap_a;
    logic [W-1:0]    tap_b;
    logic [PW-1:0]   tap_exp;
    logic [PW:0]     diff;

    logic            cmp_vld;
    logic [PW:0]     cmp_diff;
    logic [SUM_W:0]  sum_ext;
    logic [PW-1:0]   diff_clip;

    assign idx         = idx_pipe[0];
    assign idx_inc     = idx + PW'(1);
    assign last_issued = (idx == {PW{1'b1}});

    // Spread operands a and b over the partial-product grid: row i holds b[i] & a.
    function automatic logic [W*W-1:0] pp_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                p[W*i+j] = a[j] & b[i];
            end
        end
        return p;
    endfunction

    // Sweep controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a sweep ends once the last index has been issued and every
    // in-flight pair has reached the compare stage.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = SWEEP;
            SWEEP:   if (last_issued) state_nxt = DRAIN;
            DRAIN:   if (!pipe_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs and issue strobes decoded from the current state.
    always_comb begin
        busy_o      = (state == SWEEP) || (state == DRAIN);
        done_o      = (state == DONE);
        issue_first = (state == IDLE) && start_i;
        issue_next  = (state == SWEEP) && !last_issued;
    end

    // Any pair still travelling toward the compare point keeps the drain open.
    // The compare register itself retires on the same edge that leaves DRAIN,
    // so the metrics are already final while done_o is high.
    always_comb begin
        pipe_busy = 1'b0;
        for (int d = 0; d <= LAT; d++) begin
            pipe_busy = pipe_busy | vld_pipe[d];
        end
    end

    // Issue one pair per cycle. pp_o, a_o and b_o update together with the index,
    // and the index and its valid bit march down the latency pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_o <= '0;
            a_o  <= '0;
            b_o  <= '0;
            for (int d = 0; d <= LAT; d++) begin
                vld_pipe[d] <= 1'b0;
                idx_pipe[d] <= '0;
            end
        end else begin
            if (issue_first) begin
                pp_o        <= '0;
                a_o         <= '0;
                b_o         <= '0;
                vld_pipe[0] <= 1'b1;
                idx_pipe[0] <= '0;
            end else if (issue_next) begin
                pp_o        <= pp_of(idx_inc[W-1:0], idx_inc[PW-1:W]);
                a_o         <= idx_inc[W-1:0];
                b_o         <= idx_inc[PW-1:W];
                vld_pipe[0] <= 1'b1;
                idx_pipe[0] <= idx_inc;
            end else begin
                vld_pipe[0] <= 1'b0;
            end
            for (int d = 1; d <= LAT; d++) begin
                vld_pipe[d] <= vld_pipe[d-1];
                idx_pipe[d] <= idx_pipe[d-1];
            end
        end
    end

    // Exact product of the pair whose result is on res_i now, and the absolute
    // difference taken without wrap.
    always_comb begin
        tap_a   = idx_pipe[LAT][W-1:0];
        tap_b   = idx_pipe[LAT][PW-1:W];
        tap_exp = {{W{1'b0}}, tap_a} * {{W{1'b0}}, tap_b};
        if (res_i >= tap_exp) begin
            diff = {1'b0, res_i - tap_exp};
        end else begin
            diff = {1'b0, tap_exp - res_i};
        end
    end

    // Compare stage: capture the difference for the pair returning this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld  <= 1'b0;
            cmp_diff <= '0;
        end else begin
            cmp_vld  <= vld_pipe[LAT];
            cmp_diff <= vld_pipe[LAT] ? diff : '0;
        end
    end

`ifdef AP_ERR_LOG_EN
    // Error log: one pulse per erroneous pair, carrying the operands and the
    // difference. The fields are zero whenever no pulse is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_vld_o  <= 1'b0;
            err_a_o    <= '0;
            err_b_o    <= '0;
            err_diff_o <= '0;
        end else if (vld_pipe[LAT] && (diff != '0)) begin
            err_vld_o  <= 1'b1;
            err_a_o    <= tap_a;
            err_b_o    <= tap_b;
            err_diff_o <= diff;
        end else begin
            err_vld_o  <= 1'b0;
            err_a_o    <= '0;
            err_b_o    <= '0;
            err_diff_o <= '0;
        end
    end
`endif

    // Saturating helpers for the sum and maximum accumulators.
    always_comb begin
        sum_ext   = {1'b0, err_sum_o} + (SUM_W+1)'(cmp_diff);
        diff_clip = cmp_diff[PW] ? {PW{1'b1}} : cmp_diff[PW-1:0];
    end

    // Metric accumulators. They are cleared only by reset or by an accepted
    // start, so results stay readable after done_o. They saturate, never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_o <= '0;
            err_sum_o <= '0;
            err_max_o <= '0;
        end else if (issue_first) begin
            err_cnt_o <= '0;
            err_sum_o <= '0;
            err_max_o <= '0;
        end else if (cmp_vld) begin
            if ((cmp_diff != '0) && (err_cnt_o != {(PW+1){1'b1}})) begin
                err_cnt_o <= err_cnt_o + (PW+1)'(1);
            end
            err_sum_o <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            if (diff_clip > err_max_o) begin
                err_max_o <= diff_clip;
            end
        end
    end

endmodule

// File: tb/tb_ap_mult_err_eval.sv
// tb_ap_mult_err_eval: directed bench for ap_mult_err_eval. Two instances are used:
// LAT=0 with a combinational model multiplier, and LAT=2 with the model delayed
// through two registers. Expected metrics are queued when a sweep starts and are
// compared when done_o appears.

module tb_ap_mult_err_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [7:0]  res0, res1;
    logic [15:0] pp0, pp1;
    logic [3:0]  a0, b0, a1, b1;
    logic        busy0, done0, busy1, done1;
    logic [8:0]  cnt0, cnt1;
    logic [15:0] sum0, sum1;
    logic [7:0]  max0, max1;
    logic [7:0]  dly1 = 8'd0;
    logic [7:0]  dly2 = 8'd0;

    // 0 exact, 1 stuck at zero, 2 single fault at a=3 b=5, 3 exact plus one
    int mode0 = 0;
    int mode1 = 0;
    int cur = 0;
    int errors = 0;
    int checks = 0;

    logic        busy_m, done_m;
    logic [8:0]  cnt_m;
    logic [15:0] sum_m;
    logic [7:0]  max_m;

    typedef struct {
        int cnt;
        int sum;
        int mx;
        int done_cyc;
    } exp_t;

    exp_t sb[$];

`ifdef AP_ERR_LOG_EN
    logic       err_vld0, err_vld1;
    logic [3:0] err_a0, err_b0, err_a1, err_b1;
    logic [8:0] err_diff0, err_diff1;
    int         log_n = 0;
    logic [3:0] log_a = 4'd0;
    logic [3:0] log_b = 4'd0;
    logic [8:0] log_d = 9'd0;
`endif

    ap_mult_err_eval #(.W(4), .LAT(0), .SUM_W(16)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start0),
        .res_i     (res0),
        .pp_o      (pp0),
        .a_o       (a0),
        .b_o       (b0),
        .busy_o    (busy0),
        .done_o    (done0),
        .err_cnt_o (cnt0),
        .err_sum_o (sum0),
        .err_max_o (max0)
`ifdef AP_ERR_LOG_EN
        ,
        .err_vld_o (err_vld0),
        .err_a_o   (err_a0),
        .err_b_o   (err_b0),
        .err_diff_o(err_diff0)
`endif
    );

    ap_mult_err_eval #(.W(4), .LAT(2), .SUM_W(16)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start1),
        .res_i     (res1),
        .pp_o      (pp1),
        .a_o       (a1),
        .b_o       (b1),
        .busy_o    (busy1),
        .done_o    (done1),
        .err_cnt_o (cnt1),
        .err_sum_o (sum1),
        .err_max_o (max1)
`ifdef AP_ERR_LOG_EN
        ,
        .err_vld_o (err_vld1),
        .err_a_o   (err_a1),
        .err_b_o   (err_b1),
        .err_diff_o(err_diff1)
`endif
    );

    always #5 clk = ~clk;

    // Reference multiplier: weighted sum of the partial-product bits.
    function automatic logic [7:0] pp_product(input logic [15:0] pp);
        logic [7:0] p;
        p = 8'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (pp[4*i+j]) p = p + (8'd1 << (i + j));
            end
        end
        return p;
    endfunction

    // Combinational multiplier model for the LAT=0 instance.
    always_comb begin
        res0 = pp_product(pp0);
        if (mode0 == 1) res0 = 8'd0;
        else if (mode0 == 2 && pp0 == 16'h0303) res0 = 8'd14;
    end

    // Two-register delayed multiplier model for the LAT=2 instance.
    always @(posedge clk) begin
        dly1 <= pp_product(pp1);
        dly2 <= dly1;
    end

    always_comb begin
        res1 = dly2 + ((mode1 == 3) ? 8'd1 : 8'd0);
    end

    // Route the instance under test to the common observation signals.
    always_comb begin
        busy_m = (cur != 0) ? busy1 : busy0;
        done_m = (cur != 0) ? done1 : done0;
        cnt_m  = (cur != 0) ? cnt1  : cnt0;
        sum_m  = (cur != 0) ? sum1  : sum0;
        max_m  = (cur != 0) ? max1  : max0;
    end

`ifdef AP_ERR_LOG_EN
    // Record every error-log pulse from the LAT=0 instance.
    always @(negedge clk) begin
        if (err_vld0 === 1'b1) begin
            log_n = log_n + 1;
            log_a = err_a0;
            log_b = err_b0;
            log_d = err_diff0;
        end
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int sel, input int mode, input bit repulse,
                                 input int e_cnt, input int e_sum, input int e_max,
                                 input int e_done, input string tag);
        exp_t e;
        int   c;
        int   busy_bad;
        e.cnt = e_cnt;
        e.sum = e_sum;
        e.mx = e_max;
        e.done_cyc = e_done;
        sb.push_back(e);
        cur = sel;
        if (sel == 0) mode0 = mode;
        else mode1 = mode;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        c = 1;
        busy_bad = 0;
        checkOutput({tag, "_clr_cnt"}, 32'(cnt_m), 0);
        checkOutput({tag, "_clr_sum"}, 32'(sum_m), 0);
        checkOutput({tag, "_clr_max"}, 32'(max_m), 0);
        while (done_m !== 1'b1 && c < 400) begin
            if (busy_m !== 1'b1) busy_bad++;
            if (repulse && c == 50) start0 = 1'b1;
            @(negedge clk);
            c++;
            start0 = 1'b0;
        end
        e = sb.pop_front();
        checkOutput({tag, "_done_cycle"}, c, e.done_cyc);
        checkOutput({tag, "_busy_gaps"}, busy_bad, 0);
        checkOutput({tag, "_busy_at_done"}, 32'(busy_m), 0);
        checkOutput({tag, "_err_cnt"}, 32'(cnt_m), e.cnt);
        checkOutput({tag, "_err_sum"}, 32'(sum_m), e.sum);
        checkOutput({tag, "_err_max"}, 32'(max_m), e.mx);
        if (repulse) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput({tag, "_done_pulse"}, 32'(done_m), 0);
        if (repulse) begin
            @(negedge clk);
            checkOutput({tag, "_idle_busy"}, 32'(busy_m), 0);
            checkOutput({tag, "_held_cnt"}, 32'(cnt_m), e.cnt);
        end
    endtask

    initial begin
`ifdef AP_ERR_LOG_EN
        int n_before;
`endif
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_pp", 32'(pp0), 0);
        checkOutput("rst_a", 32'(a0), 0);
        checkOutput("rst_b", 32'(b0), 0);
        checkOutput("rst_busy", 32'(busy0), 0);
        checkOutput("rst_done", 32'(done0), 0);
        checkOutput("rst_cnt", 32'(cnt0), 0);
        checkOutput("rst_sum", 32'(sum0), 0);
        checkOutput("rst_max", 32'(max0), 0);
        rst = 1'b0;

        $display("[TB] LAT=0 exact multiplier");
        applyStimulus(0, 0, 1'b0, 0, 0, 0, 258, "exact");

        $display("[TB] LAT=0 result stuck at zero");
        applyStimulus(0, 1, 1'b0, 225, 14400, 225, 258, "zero");
        checkOutput("hold_pp", 32'(pp0), 32'hFFFF);
        checkOutput("hold_a", 32'(a0), 15);
        checkOutput("hold_b", 32'(b0), 15);

        $display("[TB] LAT=0 single fault at a=3 b=5");
`ifdef AP_ERR_LOG_EN
        n_before = log_n;
`endif
        applyStimulus(0, 2, 1'b0, 1, 1, 1, 258, "fault");
`ifdef AP_ERR_LOG_EN
        checkOutput("log_pulses", log_n - n_before, 1);
        checkOutput("log_a", 32'(log_a), 3);
        checkOutput("log_b", 32'(log_b), 5);
        checkOutput("log_diff", 32'(log_d), 1);
`endif

        $display("[TB] LAT=2 delayed exact and exact plus one");
        applyStimulus(1, 0, 1'b0, 0, 0, 0, 260, "lat2");
        applyStimulus(1, 3, 1'b0, 256, 256, 1, 260, "lat2p1");

        $display("[TB] start re-pulsed while busy and during done");
        applyStimulus(0, 1, 1'b1, 225, 14400, 225, 258, "repulse");
        applyStimulus(0, 0, 1'b0, 0, 0, 0, 258, "after_repulse");

        $display("[TB] asynchronous reset mid-sweep");
        cur = 0;
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (99) @(negedge clk);
        checks++;
        assert (cnt0 !== 9'd0) else begin
            errors++;
            $error("[TB] FAIL mid_cnt observed=%0d expected=nonzero", cnt0);
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_pp", 32'(pp0), 0);
        checkOutput("abort_a", 32'(a0), 0);
        checkOutput("abort_b", 32'(b0), 0);
        checkOutput("abort_busy", 32'(busy0), 0);
        checkOutput("abort_done", 32'(done0), 0);
        checkOutput("abort_cnt", 32'(cnt0), 0);
        checkOutput("abort_sum", 32'(sum0), 0);
        checkOutput("abort_max", 32'(max0), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1, 1'b0, 225, 14400, 225, 258, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ap_mult_err_eval.md
Name: ap_mult_err_eval

Overview:
- Sequential stimulus generator and error checker for the approximate 4-bit compressor-tree multipliers.
- Sweeps every operand pair (a,b) and drives the matching 16-bit partial-product vector to the multiplier under test.
- Reads back the multiplier's product and accumulates error metrics against the exact product: error count, sum of absolute error, and maximum absolute error.
- Sits beside the multiplier as the driver/reader end of its pp/res interface, in characterization and self-test harnesses.

Parameters:
- W, 4, operand width; sweep length N = 2^(2W) pairs.
- LAT, 0, cycles between a pair appearing on pp_o and its product being valid on res_i (0 = purely combinational multiplier).
- SUM_W, 16, width of the absolute-error accumulator (must hold N*(2^W-1)^2; 57600 for W=4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- res_i  in  2W  product returned by the multiplier under test.
- pp_o  out  W*W  partial products; pp_o[W*i+j] = a[j] & b[i] (row i = multiplier bit i, weight i+j).
- a_o  out  W  current operand a (debug).
- b_o  out  W  current operand b (debug).
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse when all metrics are final.
- err_cnt_o  out  2W+1  number of pairs with res_i != a*b.
- err_sum_o  out  SUM_W  sum of |res_i - a*b| over all pairs.
- err_max_o  out  2W  maximum |res_i - a*b| seen.

Behaviour:
- Reset: FSM=IDLE; pair index=0; pipeline valids cleared; every output is 0, including pp_o, a_o, b_o, busy_o, done_o and all metrics.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start_i=1 clears all three metrics and the index, then moves to SWEEP.
  - Metrics from the previous run are held until that start.
- SWEEP:
  - One pair per cycle. Index k in 0..N-1 is registered; a = k[W-1:0], b = k[2W-1:W].
  - pp_o, a_o and b_o are registered from k and update together.
  - The exact product a*b and a valid bit enter a LAT-deep shift register.
  - After index N-1 is issued, move to DRAIN. The index does not wrap.
- Compare stage:
  - Each cycle, if the valid bit at pipeline depth LAT is set, res_i is sampled.
  - diff = |res_i - exp|, computed at 2W+1 bits with no wrap.
  - err_cnt increments if diff != 0; err_sum += diff; err_max = max(err_max, diff).
- DRAIN: wait until no valid remains in the pipeline or the compare stage, then move to DONE.
- DONE:
  - done_o=1 for exactly one cycle; busy_o falls in the same cycle.
  - Return to IDLE next cycle.
- Timing: start accepted at cycle 0; pp_o shows pair k during cycle k+1; done_o asserts at cycle N+LAT+2 (258 for defaults).
- pp_o after the sweep:
  - pp_o holds the last pair (all ones) after the sweep.
  - pp_o returns to 0 only on reset or a new start.
- start_i while busy is ignored, including on the same cycle as done_o.
- rst mid-sweep aborts immediately to the reset state; partial metrics are discarded.
- Accumulators saturate at their all-ones value and never wrap; this is unreachable with the default parameters.

Optional Feature:
- Macro: AP_ERR_LOG_EN.
- Defined:
  - Adds outputs err_vld_o (1), err_a_o (W), err_b_o (W) and err_diff_o (2W+1).
  - err_vld_o pulses for one cycle, with the operands and diff, in each compare cycle where diff != 0.
  - These outputs are 0 on reset and when err_vld_o=0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Exact bench model (res_i = a*b), LAT=0 -> err_cnt=0, err_sum=0, err_max=0; done_o at cycle 258; busy_o high for cycles 1..257.
- res_i forced to 0 -> err_cnt=225, err_sum=14400 (120^2), err_max=225.
- Exact model with a single fault at a=3,b=5 returning 14 -> err_cnt=1, err_sum=1, err_max=1; with AP_ERR_LOG_EN, exactly one err_vld_o pulse carrying a=3, b=5, diff=1.
- LAT=2 with the exact model delayed two cycles through registers -> all metrics 0; done_o at cycle 260. Repeat with res_i = exact+1 -> err_cnt=256, err_sum=256, err_max=1.
- start_i re-pulsed at cycles 50 and 258 (during busy and during done_o) -> ignored; metrics match a single run; next start in IDLE clears the metrics.
- rst asserted asynchronously at cycle 100, then restart -> all outputs 0 immediately; the fresh run gives the same results as a clean run.
